// File: rtl/ecc_pkg.sv
// Shared ECC definitions: Hamming SEC position map, check-code function and
// the write-stage state enum. Used by both the encoder and the decoder side.
package ecc_pkg;

    localparam int ECC_DATA_W = 32;
    localparam int ECC_CODE_W = 6;

    // Codeword position of each data bit: the non-power-of-two slots in 1..38.
    localparam logic [5:0] DATA_POS [0:31] = '{
        6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
        6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
        6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
        6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DESC  = 2'd2
    } wr_state_e;

    function automatic logic [ECC_CODE_W-1:0] calc_code(input logic [ECC_DATA_W-1:0] data);
        logic [ECC_CODE_W-1:0] code;
        code = '0;
        for (int j = 0; j < ECC_DATA_W; j++) begin
            for (int k = 0; k < ECC_CODE_W; k++) begin
                if (DATA_POS[j][k]) begin
                    code[k] = code[k] ^ data[j];
                end
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/hamming_encoder32.sv
// Combinational 32-bit Hamming SEC encoder producing the 6-bit check code.
module hamming_encoder32
    import ecc_pkg::*;
(
    input  logic [ECC_DATA_W-1:0] i_data,
    output logic [ECC_CODE_W-1:0] o_code
);

    assign o_code = calc_code(i_data);

endmodule

// File: rtl/ecc_pkt_writer.sv
// ECC SRAM ingress write stage: encodes packet words, writes them at wrapping
// addresses and emits a (start, length) descriptor. Option: ECC_ERR_INJECT_EN.
module ecc_pkt_writer
    import ecc_pkg::*;
#(
    parameter int DATA_W = ECC_DATA_W,
    parameter int CODE_W = ECC_CODE_W,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_vld,
    input  logic              i_sop,
    input  logic              i_eop,
    output logic              o_rdy,
    input  logic [ADDR_W-1:0] i_base_addr,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic [CODE_W-1:0] o_wr_code,
    output logic              o_desc_vld,
    output logic [ADDR_W-1:0] o_desc_addr,
    output logic [LEN_W-1:0]  o_desc_len,
    input  logic              i_desc_rdy,
`ifdef ECC_ERR_INJECT_EN
    input  logic                      i_inj_en,
    input  logic [$clog2(DATA_W)-1:0] i_inj_idx,
`endif
    output logic              o_err_proto
);

    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    wr_state_e         state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [CODE_W-1:0] wr_code_q, wr_code_d;
    logic              wr_en_q, wr_en_d;
    logic              err_q, err_d;
    logic [CODE_W-1:0] enc_code;
    logic [DATA_W-1:0] data_mod;

    hamming_encoder32 u_enc (
        .i_data (i_data),
        .o_code (enc_code)
    );

    // The code always covers the clean word; injection only corrupts the stored data.
`ifdef ECC_ERR_INJECT_EN
    always_comb begin
        data_mod = i_data;
        if (i_inj_en) begin
            data_mod[i_inj_idx] = ~i_data[i_inj_idx];
        end
    end
`else
    assign data_mod = i_data;
`endif

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        start_d   = start_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_code_d = wr_code_q;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_vld) begin
                    if (i_sop) begin
                        start_d   = i_base_addr;
                        len_d     = LEN_ONE;
                        wr_en_d   = 1'b1;
                        wr_addr_d = i_base_addr;
                        wr_data_d = data_mod;
                        wr_code_d = enc_code;
                        if (i_eop) begin
                            state_d = ST_DESC;
                        end else if (LEN_ONE == LEN_MAX) begin
                            err_d   = 1'b1;
                            state_d = ST_DESC;
                        end else begin
                            state_d = ST_BURST;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_BURST: begin
                if (i_vld) begin
                    if (i_sop) begin
                        err_d = 1'b1;
                    end else begin
                        len_d     = len_q + 1'b1;
                        wr_en_d   = 1'b1;
                        wr_addr_d = wr_addr_q + 1'b1;
                        wr_data_d = data_mod;
                        wr_code_d = enc_code;
                        if (i_eop) begin
                            state_d = ST_DESC;
                        end else if (len_q + 1'b1 == LEN_MAX) begin
                            // Length field would overflow: close the packet early.
                            err_d   = 1'b1;
                            state_d = ST_DESC;
                        end
                    end
                end
            end
            ST_DESC: begin
                if (i_desc_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            start_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_code_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            start_q   <= start_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_code_q <= wr_code_d;
            err_q     <= err_d;
        end
    end

    assign o_rdy       = (state_q != ST_DESC);
    assign o_desc_vld  = (state_q == ST_DESC);
    assign o_desc_addr = start_q;
    assign o_desc_len  = len_q;
    assign o_wr_en     = wr_en_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;
    assign o_wr_code   = wr_code_q;
    assign o_err_proto = err_q;

endmodule

// File: tb/tb_ecc_pkt_writer.sv
// Self-checking bench for ecc_pkt_writer: constant vector table, directed
// multi-cycle sequences and a randomized run against a packet-level model.
module tb_ecc_pkt_writer;

    localparam int ADDR_W  = 10;
    localparam int LEN_W   = 3;
    localparam int LEN_MAX = (1 << LEN_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       data = '0;
    logic              vld = 1'b0;
    logic              sop = 1'b0;
    logic              eop = 1'b0;
    logic              rdy;
    logic [ADDR_W-1:0] base = '0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [5:0]        wr_code;
    logic              desc_vld;
    logic [ADDR_W-1:0] desc_addr;
    logic [LEN_W-1:0]  desc_len;
    logic              desc_rdy = 1'b0;
    logic              err;
`ifdef ECC_ERR_INJECT_EN
    logic              inj_en = 1'b0;
    logic [4:0]        inj_idx = '0;
`endif

    int checks = 0;
    int errors = 0;

    // Packet-level reference state
    bit          m_in_pkt, m_desc;
    int          m_count, m_start, m_last;
    bit          e_wr_en, e_err;
    logic [9:0]  e_addr;
    logic [31:0] e_data;
    logic [5:0]  e_code;

    ecc_pkt_writer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_data      (data),
        .i_vld       (vld),
        .i_sop       (sop),
        .i_eop       (eop),
        .o_rdy       (rdy),
        .i_base_addr (base),
        .o_wr_en     (wr_en),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_wr_code   (wr_code),
        .o_desc_vld  (desc_vld),
        .o_desc_addr (desc_addr),
        .o_desc_len  (desc_len),
        .i_desc_rdy  (desc_rdy),
`ifdef ECC_ERR_INJECT_EN
        .i_inj_en    (inj_en),
        .i_inj_idx   (inj_idx),
`endif
        .o_err_proto (err)
    );

    always #5 clk = ~clk;

    // Position of data bit j: the (j+1)-th integer >= 1 that is not a power of two.
    function automatic int ref_pos(input int j);
        int p = 0;
        for (int i = 0; i <= j; i++) begin
            p++;
            while ((p & (p - 1)) == 0) p++;
        end
        return p;
    endfunction

    // Check code = XOR of the positions of all set data bits.
    function automatic logic [5:0] ref_code(input logic [31:0] d);
        logic [5:0] c = '0;
        for (int j = 0; j < 32; j++) begin
            if (d[j]) c = c ^ 6'(ref_pos(j));
        end
        return c;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic recordWrite();
        e_wr_en = 1'b1;
        e_addr  = 10'(m_last);
        e_code  = ref_code(data);
        e_data  = data;
`ifdef ECC_ERR_INJECT_EN
        if (inj_en) e_data = data ^ (32'd1 << inj_idx);
`endif
    endtask

    task automatic closeOrContinue();
        if (eop) begin
            m_desc = 1'b1; m_in_pkt = 1'b0;
        end else if (m_count == LEN_MAX) begin
            e_err = 1'b1; m_desc = 1'b1; m_in_pkt = 1'b0;
        end else begin
            m_in_pkt = 1'b1;
        end
    endtask

    task automatic stepModel();
        e_wr_en = 1'b0;
        e_err   = 1'b0;
        if (rst) begin
            m_in_pkt = 1'b0; m_desc = 1'b0;
            m_count = 0; m_start = 0; m_last = 0;
            e_addr = '0; e_data = '0; e_code = '0;
        end else if (m_desc) begin
            if (desc_rdy) m_desc = 1'b0;
        end else if (vld) begin
            // A word is legal exactly when sop marks the start of a new packet.
            if (sop && !m_in_pkt) begin
                m_start = int'(base); m_count = 1; m_last = int'(base);
                recordWrite();
                closeOrContinue();
            end else if (!sop && m_in_pkt) begin
                m_count++;
                m_last = (m_last + 1) % (1 << ADDR_W);
                recordWrite();
                closeOrContinue();
            end else begin
                e_err = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input bit v, input bit s, input bit e, input logic [31:0] d,
                                 input logic [ADDR_W-1:0] b, input bit dr);
        vld = v; sop = s; eop = e; data = d; base = b; desc_rdy = dr;
        stepModel();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".wr_en"}, 32'(wr_en), 32'(e_wr_en));
        checkVal({tag, ".err"}, 32'(err), 32'(e_err));
        checkVal({tag, ".desc_vld"}, 32'(desc_vld), 32'(m_desc));
        checkVal({tag, ".rdy"}, 32'(rdy), 32'(!m_desc));
        if (e_wr_en) begin
            checkVal({tag, ".wr_addr"}, 32'(wr_addr), 32'(e_addr));
            checkVal({tag, ".wr_data"}, wr_data, e_data);
            checkVal({tag, ".wr_code"}, 32'(wr_code), 32'(e_code));
        end
        if (m_desc) begin
            checkVal({tag, ".desc_addr"}, 32'(desc_addr), 32'(m_start));
            checkVal({tag, ".desc_len"}, 32'(desc_len), 32'(m_count));
        end
    endtask

    typedef struct {
        bit          vld, sop, eop, dr;
        logic [31:0] data;
        logic [9:0]  base;
        bit          x_wr_en;
        logic [9:0]  x_addr;
        logic [5:0]  x_code;
        bit          x_err, x_dvld, x_rdy;
        logic [9:0]  x_daddr;
        logic [2:0]  x_dlen;
    } vec_t;

    vec_t vecs [8];

    initial begin
        // Single word, handshake, stray word, 4-word wrapping packet
        vecs[0] = '{1, 1, 1, 0, 32'h0000_0001, 10'h010, 1, 10'h010, 6'h03, 0, 1, 0, 10'h010, 3'd1};
        vecs[1] = '{0, 0, 0, 1, 32'h0,         10'h000, 0, 10'h000, 6'h00, 0, 0, 1, 10'h000, 3'd0};
        vecs[2] = '{1, 0, 0, 0, 32'h0000_0055, 10'h000, 0, 10'h000, 6'h00, 1, 0, 1, 10'h000, 3'd0};
        vecs[3] = '{0, 0, 0, 0, 32'h0,         10'h000, 0, 10'h000, 6'h00, 0, 0, 1, 10'h000, 3'd0};
        vecs[4] = '{1, 1, 0, 0, 32'h8000_0000, 10'h3FE, 1, 10'h3FE, 6'h26, 0, 0, 1, 10'h000, 3'd0};
        vecs[5] = '{1, 0, 0, 0, 32'h0000_0002, 10'h000, 1, 10'h3FF, 6'h05, 0, 0, 1, 10'h000, 3'd0};
        vecs[6] = '{1, 0, 0, 0, 32'h0000_0004, 10'h000, 1, 10'h000, 6'h06, 0, 0, 1, 10'h000, 3'd0};
        vecs[7] = '{1, 0, 1, 0, 32'h0000_0008, 10'h000, 1, 10'h001, 6'h07, 0, 1, 0, 10'h3FE, 3'd4};

        rst = 1'b1;
        applyStimulus(0, 0, 0, 32'h0, 10'h0, 0);
        applyStimulus(1, 1, 0, 32'hFFFF_FFFF, 10'h155, 1);
        checkVal("reset.wr_en", 32'(wr_en), 32'd0);
        checkVal("reset.wr_addr", 32'(wr_addr), 32'd0);
        checkVal("reset.wr_data", wr_data, 32'd0);
        checkVal("reset.wr_code", 32'(wr_code), 32'd0);
        checkVal("reset.err", 32'(err), 32'd0);
        checkVal("reset.desc_vld", 32'(desc_vld), 32'd0);
        checkVal("reset.desc_addr", 32'(desc_addr), 32'd0);
        checkVal("reset.desc_len", 32'(desc_len), 32'd0);
        checkVal("reset.rdy", 32'(rdy), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].vld, vecs[i].sop, vecs[i].eop, vecs[i].data, vecs[i].base, vecs[i].dr);
            checkVal($sformatf("vec%0d.wr_en", i), 32'(wr_en), 32'(vecs[i].x_wr_en));
            checkVal($sformatf("vec%0d.err", i), 32'(err), 32'(vecs[i].x_err));
            checkVal($sformatf("vec%0d.desc_vld", i), 32'(desc_vld), 32'(vecs[i].x_dvld));
            checkVal($sformatf("vec%0d.rdy", i), 32'(rdy), 32'(vecs[i].x_rdy));
            if (vecs[i].x_wr_en) begin
                checkVal($sformatf("vec%0d.wr_addr", i), 32'(wr_addr), 32'(vecs[i].x_addr));
                checkVal($sformatf("vec%0d.wr_data", i), wr_data, vecs[i].data);
                checkVal($sformatf("vec%0d.wr_code", i), 32'(wr_code), 32'(vecs[i].x_code));
            end
            if (vecs[i].x_dvld) begin
                checkVal($sformatf("vec%0d.desc_addr", i), 32'(desc_addr), 32'(vecs[i].x_daddr));
                checkVal($sformatf("vec%0d.desc_len", i), 32'(desc_len), 32'(vecs[i].x_dlen));
            end
        end

        // Descriptor back-pressure: offered words must not be taken.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 1, 32'hDEAD_BEEF, 10'h123, 0);
            checkVal($sformatf("hold%0d.rdy", i), 32'(rdy), 32'd0);
            checkVal($sformatf("hold%0d.desc_vld", i), 32'(desc_vld), 32'd1);
            checkVal($sformatf("hold%0d.desc_addr", i), 32'(desc_addr), 32'h3FE);
            checkVal($sformatf("hold%0d.desc_len", i), 32'(desc_len), 32'd4);
            checkVal($sformatf("hold%0d.wr_en", i), 32'(wr_en), 32'd0);
        end
        applyStimulus(0, 0, 0, 32'h0, 10'h0, 1);
        checkVal("hold_release.rdy", 32'(rdy), 32'd1);
        checkVal("hold_release.desc_vld", 32'(desc_vld), 32'd0);

        // Overlong packet: forced close at LEN_MAX words, remaining words dropped later.
        for (int i = 0; i < LEN_MAX + 2; i++) begin
            applyStimulus(1, i == 0, 0, 32'(i) * 32'h0101_0101, 10'h100, 0);
            checkOutput($sformatf("ovf%0d", i));
        end
        checkVal("ovf.desc_len", 32'(desc_len), 32'(LEN_MAX));
        applyStimulus(0, 0, 0, 32'h0, 10'h0, 1);
        checkOutput("ovf_hs");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 0, 0, 32'h1234_0000 + 32'(i), 10'h0, 0);
            checkOutput($sformatf("ovf_drop%0d", i));
            checkVal($sformatf("ovf_drop%0d.err_pulse", i), 32'(err), 32'd1);
            applyStimulus(0, 0, 0, 32'h0, 10'h0, 0);
            checkVal($sformatf("ovf_drop%0d.err_clear", i), 32'(err), 32'd0);
        end

        // Reset mid-packet: no descriptor afterwards.
        applyStimulus(1, 1, 0, 32'hA5A5_0001, 10'h200, 0);
        checkOutput("midrst0");
        applyStimulus(1, 0, 0, 32'hA5A5_0002, 10'h0, 0);
        checkOutput("midrst1");
        rst = 1'b1;
        applyStimulus(1, 0, 1, 32'hA5A5_0003, 10'h0, 0);
        checkOutput("midrst2");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 32'h0, 10'h0, 0);
            checkOutput($sformatf("midrst_idle%0d", i));
        end

`ifdef ECC_ERR_INJECT_EN
        begin
            logic [5:0]  syn;
            logic [31:0] fixed;
            inj_en = 1'b1; inj_idx = 5'd0;
            applyStimulus(1, 1, 1, 32'h0, 10'h020, 0);
            inj_en = 1'b0;
            checkVal("inj.wr_data", wr_data, 32'h1);
            checkVal("inj.wr_code", 32'(wr_code), 32'h0);
            syn = ref_code(wr_data) ^ wr_code;
            fixed = wr_data;
            for (int j = 0; j < 32; j++) begin
                if (6'(ref_pos(j)) == syn) fixed[j] = ~fixed[j];
            end
            checkVal("inj.dec_flag", 32'(syn != 6'd0), 32'd1);
            checkVal("inj.dec_data", fixed, 32'h0);
            applyStimulus(0, 0, 0, 32'h0, 10'h0, 1);
            checkOutput("inj_hs");
        end
`endif

        // Randomized traffic against the packet model.
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 99) < 2);
`ifdef ECC_ERR_INJECT_EN
            inj_en  = ($urandom_range(0, 9) < 2);
            inj_idx = 5'($urandom_range(0, 31));
`endif
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                          $urandom_range(0, 9) < 2, $urandom,
                          10'($urandom_range(0, 1023)), $urandom_range(0, 1) == 1);
            checkOutput($sformatf("rand%0d", i));
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
